rrt_multi: RTL

- Parametrised successor of the two-wide register renaming table.
- Renames DECODE_WIDTH instructions per cycle with in-group dependency bypass.
- Tracks busy state (value in ROB/in flight vs. in PRF) per architectural register, with WB_PORTS writeback channels.
- Keeps a committed (architectural) map so a pipeline flush restores the speculative map in one cycle. Sits between decode/free-list and dispatch/ROB.

---
 rtl/rrt_multi.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/rrt_multi.sv
// rrt_multi: parametrised register renaming table with in-group bypass, busy tracking and flush recovery
//   Optional feature macro: RRT_CKPT_EN (adds ckpt_take_i / ckpt_restore_i and one map+busy snapshot)
//   Ports:
//     clk, rst                          clock, asynchronous active-high reset
//     rn_valid_i, rn_uses_rd_i          per-lane rename request / writes rd
//     rn_rs1_i, rn_rs2_i, rn_rd_i       architectural operands, lane i at [i*R +: R]
//     rn_prd_i                          new physical rd per lane from the free list
//     rn_prs1_o, rn_prs2_o              renamed sources (registered)
//     rn_lprd_o                         previous mapping of rd (registered)
//     rn_rs1_busy_o, rn_rs2_busy_o      source not yet in PRF (registered)
//     wb_valid_i, wb_rd_i, wb_prd_i     writeback channels clearing busy bits
//     cm_valid_i, cm_rd_i, cm_prd_i     commit lanes updating the committed map
//     flush_i                           restore speculative map from committed map
//     busy_o                            current busy vector
module rrt_multi #(
    parameter int DECODE_WIDTH       = 2,
    parameter int WB_PORTS           = 3,
    parameter int COMMIT_WIDTH       = 2,
    parameter int ARCH_REGS          = 32,
    parameter int REG_ADDR_WIDTH     = 5,
    parameter int PHY_REG_ADDR_WIDTH = 6
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [DECODE_WIDTH-1:0]                    rn_valid_i,
    input  logic [DECODE_WIDTH-1:0]                    rn_uses_rd_i,
    input  logic [DECODE_WIDTH*REG_ADDR_WIDTH-1:0]     rn_rs1_i,
    input  logic [DECODE_WIDTH*REG_ADDR_WIDTH-1:0]     rn_rs2_i,
    input  logic [DECODE_WIDTH*REG_ADDR_WIDTH-1:0]     rn_rd_i,
    input  logic [DECODE_WIDTH*PHY_REG_ADDR_WIDTH-1:0] rn_prd_i,
    output logic [DECODE_WIDTH*PHY_REG_ADDR_WIDTH-1:0] rn_prs1_o,
    output logic [DECODE_WIDTH*PHY_REG_ADDR_WIDTH-1:0] rn_prs2_o,
    output logic [DECODE_WIDTH*PHY_REG_ADDR_WIDTH-1:0] rn_lprd_o,
    output logic [DECODE_WIDTH-1:0]                    rn_rs1_busy_o,
    output logic [DECODE_WIDTH-1:0]                    rn_rs2_busy_o,
    input  logic [WB_PORTS-1:0]                        wb_valid_i,
    input  logic [WB_PORTS*REG_ADDR_WIDTH-1:0]         wb_rd_i,
    input  logic [WB_PORTS*PHY_REG_ADDR_WIDTH-1:0]     wb_prd_i,
    input  logic [COMMIT_WIDTH-1:0]                    cm_valid_i,
    input  logic [COMMIT_WIDTH*REG_ADDR_WIDTH-1:0]     cm_rd_i,
    input  logic [COMMIT_WIDTH*PHY_REG_ADDR_WIDTH-1:0] cm_prd_i,
    input  logic                                       flush_i,
`ifdef RRT_CKPT_EN
    input  logic                                       ckpt_take_i,
    input  logic                                       ckpt_restore_i,
`endif
    output logic [ARCH_REGS-1:0]                       busy_o
);
    localparam int R = REG_ADDR_WIDTH;
    localparam int P = PHY_REG_ADDR_WIDTH;

    logic [P-1:0]              r_spec     [ARCH_REGS];
    logic [P-1:0]              r_cmt      [ARCH_REGS];
    logic [ARCH_REGS-1:0]      r_busy;
    logic [P-1:0]              w_spec_nxt [ARCH_REGS];
    logic [P-1:0]              w_cmt_nxt  [ARCH_REGS];
    logic [ARCH_REGS-1:0]      w_busy_nxt;
    logic [DECODE_WIDTH-1:0]   w_we;
    logic [DECODE_WIDTH*P-1:0] w_prs1, w_prs2, w_lprd;
    logic [DECODE_WIDTH-1:0]   w_b1, w_b2;
    logic                      w_drop;

`ifdef RRT_CKPT_EN
    logic [P-1:0]              r_snap [ARCH_REGS];
    logic [ARCH_REGS-1:0]      r_snap_busy;
    logic [ARCH_REGS-1:0]      w_snap_busy_clr;
    // renames are discarded whenever the speculative state is being replaced
    assign w_drop = flush_i | ckpt_restore_i;
`else
    assign w_drop = flush_i;
`endif

    assign busy_o = r_busy;

    // lane write enables and source/old-rd lookup with youngest-older-lane bypass
    always_comb begin
        w_prs1 = '0;
        w_prs2 = '0;
        w_lprd = '0;
        w_b1   = '0;
        w_b2   = '0;
        for (int i = 0; i < DECODE_WIDTH; i++)
            w_we[i] = rn_valid_i[i] & rn_uses_rd_i[i] & (rn_rd_i[i*R +: R] != '0) & ~w_drop;
        for (int j = 0; j < DECODE_WIDTH; j++) begin
            w_prs1[j*P +: P] = r_spec[rn_rs1_i[j*R +: R]];
            w_prs2[j*P +: P] = r_spec[rn_rs2_i[j*R +: R]];
            w_lprd[j*P +: P] = r_spec[rn_rd_i[j*R +: R]];
            w_b1[j]          = r_busy[rn_rs1_i[j*R +: R]];
            w_b2[j]          = r_busy[rn_rs2_i[j*R +: R]];
            for (int i = 0; i < DECODE_WIDTH; i++) begin
                if (i < j && w_we[i] && rn_rd_i[i*R +: R] == rn_rs1_i[j*R +: R]) begin
                    w_prs1[j*P +: P] = rn_prd_i[i*P +: P];
                    w_b1[j]          = 1'b1;
                end
                if (i < j && w_we[i] && rn_rd_i[i*R +: R] == rn_rs2_i[j*R +: R]) begin
                    w_prs2[j*P +: P] = rn_prd_i[i*P +: P];
                    w_b2[j]          = 1'b1;
                end
                if (i < j && w_we[i] && rn_rd_i[i*R +: R] == rn_rd_i[j*R +: R])
                    w_lprd[j*P +: P] = rn_prd_i[i*P +: P];
            end
        end
    end

    // next committed map, speculative map and busy vector
    always_comb begin
        w_cmt_nxt  = r_cmt;
        w_spec_nxt = r_spec;
        w_busy_nxt = r_busy;
        for (int k = 0; k < COMMIT_WIDTH; k++)
            if (cm_valid_i[k] && cm_rd_i[k*R +: R] != '0)
                w_cmt_nxt[cm_rd_i[k*R +: R]] = cm_prd_i[k*P +: P];
        // stale writebacks (mapping already moved on) leave busy untouched
        for (int k = 0; k < WB_PORTS; k++)
            if (wb_valid_i[k] && r_spec[wb_rd_i[k*R +: R]] == wb_prd_i[k*P +: P])
                w_busy_nxt[wb_rd_i[k*R +: R]] = 1'b0;
        // renames applied after clears so a rename always wins on the same register
        for (int i = 0; i < DECODE_WIDTH; i++)
            if (w_we[i]) begin
                w_spec_nxt[rn_rd_i[i*R +: R]] = rn_prd_i[i*P +: P];
                w_busy_nxt[rn_rd_i[i*R +: R]] = 1'b1;
            end
        w_busy_nxt[0] = 1'b0;
`ifdef RRT_CKPT_EN
        if (ckpt_restore_i) begin
            w_spec_nxt = r_snap;
            w_busy_nxt = w_snap_busy_clr;
        end
`endif
        if (flush_i) begin
            w_spec_nxt = w_cmt_nxt;
            w_busy_nxt = '0;
        end
    end

`ifdef RRT_CKPT_EN
    always_comb begin
        w_snap_busy_clr = r_snap_busy;
        for (int k = 0; k < WB_PORTS; k++)
            if (wb_valid_i[k] && r_snap[wb_rd_i[k*R +: R]] == wb_prd_i[k*P +: P])
                w_snap_busy_clr[wb_rd_i[k*R +: R]] = 1'b0;
        w_snap_busy_clr[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_snap_busy <= '0;
        else
            r_snap_busy <= (ckpt_take_i && !w_drop) ? w_busy_nxt : w_snap_busy_clr;
    end
`endif

    // map entries reset to the identity mapping
    for (genvar g = 0; g < ARCH_REGS; g++) begin : g_map
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_spec[g] <= P'(g);
                r_cmt[g]  <= P'(g);
            end else begin
                r_spec[g] <= w_spec_nxt[g];
                r_cmt[g]  <= w_cmt_nxt[g];
            end
        end
`ifdef RRT_CKPT_EN
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_snap[g] <= P'(g);
            else if (ckpt_take_i && !w_drop)
                r_snap[g] <= w_spec_nxt[g];
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy        <= '0;
            rn_prs1_o     <= '0;
            rn_prs2_o     <= '0;
            rn_lprd_o     <= '0;
            rn_rs1_busy_o <= '0;
            rn_rs2_busy_o <= '0;
        end else begin
            r_busy        <= w_busy_nxt;
            rn_prs1_o     <= w_prs1;
            rn_prs2_o     <= w_prs2;
            rn_lprd_o     <= w_lprd;
            rn_rs1_busy_o <= w_b1;
            rn_rs2_busy_o <= w_b2;
        end
    end
endmodule
